otf_conv_r4: RTL and testbench

Radix-4 on-the-fly converter that sits directly downstream of the radix-4 online adder/subtractor. It consumes the MSD-first signed-digit stream `di` (one digit per enabled cycle) and incrementally builds the two's-complement integer value without a final carry-propagate addition. It discards the producer's online-delay warm-up digits, accumulates N digits, then presents the result with a one-cycle `done` pulse.

---
 rtl/otf_conv_r4.sv | 122 ++++++++++++
 tb/tb_otf_conv_r4.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/otf_conv_r4.sv
// Radix-4 on-the-fly converter: turns an MSD-first signed-digit stream into a
// two's-complement integer. Optional illegal-digit flag under OTF_R4_DIGIT_CHECK_EN.
module otf_conv_r4 #(
    parameter int N     = 8,
    parameter int DELAY = 2,
    parameter int W     = 2*N+1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    input  logic [2:0]   di,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         done
`ifdef OTF_R4_DIGIT_CHECK_EN
    ,
    output logic         err
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // SKIP  | discarding producer warm-up digits
    // CONV  | one on-the-fly step per enabled cycle
    // DONE  | q valid, done high for one clock
    typedef enum logic [1:0] {IDLE, SKIP, CONV, DONE} state_t;

    localparam int SW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state;
    logic [SW-1:0]  skip_cnt;
    logic [CW-1:0]  dig_cnt;
    logic [W-1:0]   qa, qma;
    logic [W-1:0]   qa4, qma4, d_ext;
    logic [W-1:0]   qa_nx, qma_nx;
    logic           start_ok;

    assign start_ok = en && start && (state == IDLE || state == DONE);

    always_comb begin
        d_ext = {{(W-3){di[2]}}, di};
        qa4   = {qa[W-3:0], 2'b00};
        qma4  = {qma[W-3:0], 2'b00};
        // Negative digits borrow from QMa so no carry ripples through Qa.
        if (!di[2])
            qa_nx = qa4 + d_ext;
        else
            qa_nx = qma4 + W'(4) + d_ext;
        if (!di[2] && (di != 3'b000))
            qma_nx = qa4 + d_ext - W'(1);
        else
            qma_nx = qma4 + W'(3) + d_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= '0;
            dig_cnt  <= '0;
            qa       <= '0;
            qma      <= '1;
            q        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef OTF_R4_DIGIT_CHECK_EN
            err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start_ok) begin
                        qa       <= '0;
                        qma      <= '1;
                        dig_cnt  <= '0;
                        skip_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= (DELAY > 0) ? SKIP : CONV;
`ifdef OTF_R4_DIGIT_CHECK_EN
                        err      <= 1'b0;
`endif
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SKIP: begin
                    if (en) begin
                        if (skip_cnt == SW'(DELAY-1)) begin
                            skip_cnt <= '0;
                            state    <= CONV;
                        end else begin
                            skip_cnt <= skip_cnt + 1'b1;
                        end
                    end
                end
                CONV: begin
                    if (en) begin
                        qa  <= qa_nx;
                        qma <= qma_nx;
`ifdef OTF_R4_DIGIT_CHECK_EN
                        if (di == 3'b100)
                            err <= 1'b1;
`endif
                        if (dig_cnt == CW'(N-1)) begin
                            q     <= qa_nx;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            dig_cnt <= dig_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_otf_conv_r4.sv
// Directed bench for otf_conv_r4 at default parameters (N=8, DELAY=2).
module tb_otf_conv_r4;

    localparam int N = 8;
    localparam int W = 2*N+1;
    localparam logic [2:0] M1 = 3'b111, M2 = 3'b110, M3 = 3'b101, BAD = 3'b100;

    logic         clk = 1'b0;
    logic         reset, en, start;
    logic [2:0]   di;
    logic [W-1:0] q;
    logic         busy, done;
`ifdef OTF_R4_DIGIT_CHECK_EN
    logic         err;
`endif

    otf_conv_r4 dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .di(di),
        .q(q), .busy(busy), .done(done)
`ifdef OTF_R4_DIGIT_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int last_q = 0;
    bit last_valid = 1'b1;

    typedef struct {
        logic [0:7][2:0] d;
        int              exp;
        bit              chkq;
        int              stall_k;
        bit              poke;
        bit              chain;
        logic [2:0]      junk;
    } vec_t;

    vec_t v[9];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic conv(input vec_t t, input bit skip_start);
        bit e = 1'b0;
        for (int k = 0; k < 8; k++) if (t.d[k] == BAD) e = 1'b1;
        if (!skip_start) begin
            @(negedge clk); start = 1'b1; en = 1'b1; di = t.junk;
            @(posedge clk);
        end
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); start = 1'b0; en = 1'b1; di = t.junk;
            chk("skip_busy", int'(busy), 1);
            chk("skip_done", int'(done), 0);
            if (s == 0 && last_valid) chk("q_hold", int'($signed(q)), last_q);
`ifdef OTF_R4_DIGIT_CHECK_EN
            if (s == 0) chk("err_clr", int'(err), 0);
`endif
            @(posedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            if (k == t.stall_k) begin
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk); en = 1'b0; di = t.junk;
                    chk("stall_busy", int'(busy), 1);
                    chk("stall_done", int'(done), 0);
                    @(posedge clk);
                end
            end
            @(negedge clk); en = 1'b1; di = t.d[k]; start = t.poke && (k == 4);
            chk("conv_busy", int'(busy), 1);
            chk("conv_done", int'(done), 0);
            @(posedge clk);
        end
        @(negedge clk); start = t.chain; en = 1'b1; di = 3'b000;
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 0);
        if (t.chkq) chk("q_value", int'($signed(q)), t.exp);
`ifdef OTF_R4_DIGIT_CHECK_EN
        chk("err_done", int'(err), int'(e));
`endif
        last_q = int'($signed(q));
        last_valid = t.chkq;
        @(posedge clk);
        if (!t.chain) begin
            @(negedge clk); start = 1'b0;
            chk("done_drop", int'(done), 0);
            chk("idle_busy", int'(busy), 0);
`ifdef OTF_R4_DIGIT_CHECK_EN
            chk("err_sticky", int'(err), int'(e));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        v[0] = '{'{3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 16384, 1, -1, 0, 0, 3'd2};
        v[1] = '{'{3'd1,M1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 12288, 1, -1, 0, 0, 3'd3};
        v[2] = '{'{3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,M1}, -1, 1, -1, 0, 0, M3};
        v[3] = '{'{M3,M3,M3,M3,M3,M3,M3,M3}, -65535, 1, -1, 0, 1, 3'd1};
        v[4] = '{'{3'd3,3'd3,3'd3,3'd3,3'd3,3'd3,3'd3,3'd3}, 65535, 1, -1, 0, 0, M2};
        v[5] = '{'{3'd2,M3,3'd1,3'd0,3'd3,M2,M1,3'd2}, 21662, 1, 3, 0, 0, 3'd1};
        v[6] = '{'{M2,3'd1,3'd0,M3,3'd2,3'd0,M1,3'd1}, -29315, 1, -1, 1, 0, 3'd3};
        v[7] = '{'{3'd1,BAD,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 0, 0, -1, 0, 0, 3'd0};
        v[8] = '{'{3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd1,3'd0}, 4, 1, -1, 0, 0, BAD};

        reset = 1'b1; en = 1'b0; start = 1'b0; di = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
`ifdef OTF_R4_DIGIT_CHECK_EN
        chk("rst_err", int'(err), 0);
`endif

        for (int i = 0; i < 9; i++)
            conv(v[i], (i > 0) && v[i-1].chain);

        // Abort a conversion with reset in cycle 6.
        @(negedge clk); start = 1'b1; en = 1'b1; di = 3'd0;
        @(posedge clk);
        for (int c = 1; c < 6; c++) begin
            @(negedge clk); start = 1'b0; di = 3'd1;
            @(posedge clk);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        chk("abort_q", int'(q), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end

        // Reset wins over a simultaneous start.
        @(negedge clk); reset = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0; start = 1'b0;
        chk("rst_prio_busy", int'(busy), 0);
        @(posedge clk); @(negedge clk);
        chk("rst_prio_idle", int'(busy), 0);

        last_q = 0; last_valid = 1'b1;
        conv(v[1], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
